// File: rtl/lsu_ctrl.sv
// Load/store initiator: issues aligned MEM accesses for CPU loads and stores,
// splitting word-crossing loads into two reads and misaligned stores into byte writes.
module lsu_ctrl #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_write_enable,
  output logic [2:0]  mem_write_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_STB, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] w0_q, w0_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  // Access size minus one: byte 0, half 1, word 3.
  function automatic logic [1:0] size_m1(input logic [1:0] t);
    case (t)
      2'd0:    size_m1 = 2'd0;
      2'd1:    size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  endfunction

  // Pick the access bytes starting at offset off from the big-endian pair {hi, lo}.
  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off, input logic [2:0] t);
    logic [31:0] top;
    top = (hi << {off, 3'b000}) | (lo >> (6'd32 - {1'b0, off, 3'b000}));
    case (t[1:0])
      2'd0:    extract = {{24{top[31] & ~t[2]}}, top[31:24]};
      2'd1:    extract = {{16{top[31] & ~t[2]}}, top[31:16]};
      default: extract = top;
    endcase
  endfunction

  logic [1:0]  req_m1, cur_m1, byte_sel;
  logic        req_illegal, req_misal, crossing;
  logic [31:0] word_addr, store_mask;

  always_comb begin
    req_m1      = size_m1(req_type[1:0]);
    req_illegal = req_write ? (req_type >= 3'd3)
                            : (req_type == 3'd3 || req_type[2:1] == 2'b11);
    req_misal   = (req_addr[1:0] & req_m1) != 2'd0;
    cur_m1      = size_m1(type_q[1:0]);
    crossing    = ({1'b0, addr_q[1:0]} + {1'b0, cur_m1}) > 3'd3;
    word_addr   = {addr_q[31:2], 2'b00};
    byte_sel    = cur_m1 - cnt_q;
    case (type_q[1:0])
      2'd0:    store_mask = 32'h0000_00FF;
      2'd1:    store_mask = 32'h0000_FFFF;
      default: store_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    w0_d        = w0_q;
    cnt_d       = cnt_q;
    resp_data_d = 32'd0;
    resp_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 2'd0;
          if (req_illegal || (req_misal && !MISALIGN_EN)) begin
            state_d    = S_RESP;
            resp_err_d = 1'b1;
          end else if (req_write && req_misal) begin
            state_d = S_STB;
          end else begin
            state_d = S_ACC0;
          end
        end
      end
      S_ACC0: begin
        if (write_q) begin
          state_d = S_RESP;
        end else if (crossing) begin
          w0_d    = mem_rdata;
          state_d = S_ACC1;
        end else begin
          resp_data_d = extract(mem_rdata, 32'd0, addr_q[1:0], type_q);
          state_d     = S_RESP;
        end
      end
      S_ACC1: begin
        resp_data_d = extract(w0_q, mem_rdata, addr_q[1:0], type_q);
        state_d     = S_RESP;
      end
      S_STB: begin
        if (cnt_q == cur_m1) state_d = S_RESP;
        else                 cnt_d   = cnt_q + 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MEM drive decodes only captured state, so req_* changes while busy cannot leak out.
  // Aligned stores keep the byte address so MEM can place sub-word data.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_write_type   = 3'd0;
    mem_addr         = 32'd0;
    mem_wdata        = 32'd0;
    case (state_q)
      S_ACC0: begin
        mem_addr = write_q ? addr_q : word_addr;
        if (write_q) begin
          mem_write_enable = 1'b1;
          mem_write_type   = type_q;
          mem_wdata        = wdata_q & store_mask;
        end
      end
      S_ACC1: mem_addr = word_addr + 32'd4;
      S_STB: begin
        mem_write_enable = 1'b1;
        mem_addr         = addr_q + {30'd0, cnt_q};
        mem_wdata        = {24'd0, wdata_q[{byte_sel, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      type_q      <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      w0_q        <= 32'd0;
      cnt_q       <= 2'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      w0_q        <= w0_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

endmodule
